// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// A transfer happens in any cycle where imem_req and imem_ack are both high.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single outstanding imem request, one-entry skid
// and a registered output slot feeding the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_in,
    input  logic                 redirect_in,
    input  logic [31:0]          redirect_pc_in,
    fetch_stage_if.master        imem,
    output logic [31:0]          instruction_out,
    output logic [31:0]          pc_plus4_out,
    output logic                 valid_out,
    output logic [1:0]           state_dbg
);
    // Handshake: imem_req stays high with imem_addr stable until a cycle with
    // imem_ack; that cycle is the transfer and imem_rdata is sampled then.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_DROP = 2'd1,
        S_SKID = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic        transfer;
    logic        slot_free;
    logic [31:0] target;
    logic [31:0] addr_plus4;

    assign imem.imem_req  = ((state_q == S_REQ) || (state_q == S_DROP)) && reset;
    assign imem.imem_addr = addr_q;
    assign transfer       = imem.imem_req && imem.imem_ack;
    assign slot_free      = !valid_q || !stall_in;
    assign target         = redirect_pc_in & ~32'h3;
    assign addr_plus4     = addr_q + 32'd4;

    assign instruction_out = instr_q;
    assign pc_plus4_out    = pc4_q;
    assign valid_out       = valid_q;
    assign state_dbg       = state_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;

        if (valid_q && !stall_in) begin
            valid_d = 1'b0;
            instr_d = 32'h0;
            pc4_d   = 32'h0;
        end

        case (state_q)
            S_REQ: begin
                if (redirect_in) begin
                    pc_d = target;
                    if (transfer) addr_d = target;
                    else          state_d = S_DROP;
                end else if (transfer) begin
                    pc_d = addr_plus4;
                    if (slot_free) begin
                        instr_d = imem.imem_rdata;
                        pc4_d   = addr_plus4;
                        valid_d = 1'b1;
                        addr_d  = addr_plus4;
                    end else begin
                        skid_instr_d = imem.imem_rdata;
                        skid_pc4_d   = addr_plus4;
                        state_d      = S_SKID;
                    end
                end
            end
            S_DROP: begin
                // The old request must complete before the new address is issued.
                if (redirect_in) pc_d = target;
                if (transfer) begin
                    addr_d  = redirect_in ? target : pc_q;
                    state_d = S_REQ;
                end
            end
            S_SKID: begin
                if (redirect_in) begin
                    pc_d         = target;
                    addr_d       = target;
                    skid_instr_d = 32'h0;
                    skid_pc4_d   = 32'h0;
                    state_d      = S_REQ;
                end else if (slot_free) begin
                    instr_d = skid_instr_q;
                    pc4_d   = skid_pc4_q;
                    valid_d = 1'b1;
                    addr_d  = pc_q;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // A redirect flushes the wrong-path instruction regardless of stall or load.
        if (redirect_in) begin
            valid_d = 1'b0;
            instr_d = 32'h0;
            pc4_d   = 32'h0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC & ~32'h3;
            addr_q       <= RESET_PC & ~32'h3;
            skid_instr_q <= 32'h0;
            skid_pc4_q   <= 32'h0;
            instr_q      <= 32'h0;
            pc4_q        <= 32'h0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stalls, wait states
// and redirects, checked against an in-order program-stream scoreboard.
module tb_fetch_stage;
    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_DROP = 2'd1;
    localparam logic [1:0] ST_SKID = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_in = 1'b0;
    logic        redirect_in = 1'b0;
    logic [31:0] redirect_pc_in = 32'h0;
    logic [31:0] instruction_out;
    logic [31:0] pc_plus4_out;
    logic        valid_out;
    logic [1:0]  state_dbg;

    fetch_stage_if bus();

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall_in        (stall_in),
        .redirect_in     (redirect_in),
        .redirect_pc_in  (redirect_pc_in),
        .imem            (bus),
        .instruction_out (instruction_out),
        .pc_plus4_out    (pc_plus4_out),
        .valid_out       (valid_out),
        .state_dbg       (state_dbg)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          min_wait = 0;
    int          max_wait = 0;
    logic [63:0] exp_q[$];
    logic [31:0] next_push_pc = 32'h0;

    // Program image: every word address holds a distinct, address-derived value.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream: sequential words from the last fetch start point.
    task automatic sb_fill();
        while (exp_q.size() < 8) begin
            exp_q.push_back({next_push_pc + 32'd4, mem_word(next_push_pc)});
            next_push_pc = next_push_pc + 32'd4;
        end
    endtask

    task automatic sb_restart(input logic [31:0] start);
        exp_q.delete();
        next_push_pc = start;
        sb_fill();
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect_in    = 1'b1;
        redirect_pc_in = t;
        sb_restart(t & ~32'h3);
    endtask

    task automatic wait_state(input logic [1:0] s, input string name);
        int n = 0;
        while (state_dbg !== s && n < 30) begin
            @(negedge clk); #2;
            n++;
        end
        chk(name, {30'h0, state_dbg}, {30'h0, s});
    endtask

    // Memory responder with a random number of wait states per request.
    initial begin
        int remaining = 0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        forever begin
            @(negedge clk); #1;
            if (!bus.imem_req) begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = $urandom;
                remaining      = $urandom_range(max_wait, min_wait);
            end else if (remaining == 0) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem_word(bus.imem_addr);
                remaining      = $urandom_range(max_wait, min_wait);
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = $urandom;
                remaining--;
            end
        end
    end

    // Monitor: pops one expected entry for each instruction IF/ID accepts.
    initial begin
        int          idle = 0;
        logic [63:0] e;
        forever begin
            @(negedge clk); #4;
            if (!reset) begin
                idle = 0;
                continue;
            end
            if (!valid_out) begin
                chk("idle_instr", instruction_out, 32'h0);
                chk("idle_pc4", pc_plus4_out, 32'h0);
            end
            if (redirect_in) begin
                idle = 0;
            end else if (valid_out && !stall_in) begin
                idle = 0;
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc4", pc_plus4_out, e[63:32]);
                    chk("sb_instr", instruction_out, e[31:0]);
                    sb_fill();
                end
            end else begin
                idle++;
                if (idle == 60) begin
                    chk("progress_timeout", idle, 32'd0);
                    idle = 0;
                end
            end
        end
    end

    initial begin
        int n;
        sb_restart(32'h0);

        // Reset state
        #12;
        chk("rst_req", {31'h0, bus.imem_req}, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", {31'h0, valid_out}, 32'd0);
        chk("rst_instr", instruction_out, 32'h0);
        chk("rst_pc4", pc_plus4_out, 32'h0);
        chk("rst_state", {30'h0, state_dbg}, {30'h0, ST_REQ});

        // Zero-wait streaming from RESET_PC
        @(negedge clk);
        reset = 1'b1;
        #2;
        chk("first_req", {31'h0, bus.imem_req}, 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); #2;
            chk("stream_addr", bus.imem_addr, 32'(4 * i));
            chk("stream_valid", {31'h0, valid_out}, 32'd1);
            chk("stream_pc4", pc_plus4_out, 32'(4 * i));
            chk("stream_instr", instruction_out, mem_word(32'(4 * (i - 1))));
        end

        // Three-cycle stall with a transfer landing in the skid
        @(negedge clk);
        stall_in = 1'b1;
        #2 chk("stall_pc4", pc_plus4_out, 32'd16);
        @(negedge clk); #2;
        chk("skid_state", {30'h0, state_dbg}, {30'h0, ST_SKID});
        chk("skid_req", {31'h0, bus.imem_req}, 32'd0);
        chk("skid_hold_pc4", pc_plus4_out, 32'd16);
        @(negedge clk);
        @(negedge clk);
        stall_in = 1'b0;
        @(negedge clk); #2;
        chk("unskid_pc4", pc_plus4_out, 32'd20);
        chk("unskid_addr", bus.imem_addr, 32'd20);
        chk("unskid_state", {30'h0, state_dbg}, {30'h0, ST_REQ});

        // Redirect during a wait state
        @(negedge clk);
        min_wait = 2;
        max_wait = 2;
        #2 chk("resume_pc4", pc_plus4_out, 32'd24);
        @(negedge clk);
        do_redirect(32'h0000_0100);
        #2 chk("pre_redir_pc4", pc_plus4_out, 32'd28);
        @(negedge clk);
        redirect_in = 1'b0;
        #2;
        chk("drop_valid", {31'h0, valid_out}, 32'd0);
        chk("drop_state", {30'h0, state_dbg}, {30'h0, ST_DROP});
        chk("drop_addr", bus.imem_addr, 32'd28);
        @(negedge clk); #2;
        chk("drop_hold_addr", bus.imem_addr, 32'd28);
        chk("drop_ack", {31'h0, bus.imem_ack}, 32'd1);
        @(negedge clk); #2;
        chk("redir_addr", bus.imem_addr, 32'h100);
        chk("redir_state", {30'h0, state_dbg}, {30'h0, ST_REQ});
        chk("redir_valid", {31'h0, valid_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #2;
        chk("target_valid", {31'h0, valid_out}, 32'd1);
        chk("target_pc4", pc_plus4_out, 32'h104);
        chk("target_instr", instruction_out, mem_word(32'h100));

        // Redirect with stall held and the skid full
        min_wait = 0;
        max_wait = 0;
        @(negedge clk);
        stall_in = 1'b1;
        wait_state(ST_SKID, "fill_skid");
        @(negedge clk);
        do_redirect(32'h0000_0201);
        @(negedge clk);
        redirect_in = 1'b0;
        stall_in    = 1'b0;
        #2;
        chk("flush_valid", {31'h0, valid_out}, 32'd0);
        chk("flush_pc4", pc_plus4_out, 32'h0);
        chk("flush_state", {30'h0, state_dbg}, {30'h0, ST_REQ});
        chk("flush_addr", bus.imem_addr, 32'h200);
        chk("flush_req", {31'h0, bus.imem_req}, 32'd1);

        // Redirect to the top of the address space: fetch wraps to zero
        @(negedge clk);
        do_redirect(32'hFFFF_FFFF);
        @(negedge clk);
        redirect_in = 1'b0;
        #2 chk("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk); #2;
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_valid", {31'h0, valid_out}, 32'd1);
        chk("wrap_pc4", pc_plus4_out, 32'h0);
        chk("wrap_instr", instruction_out, mem_word(32'hFFFF_FFFC));

        // Asynchronous reset while a dropped request is pending
        min_wait = 3;
        max_wait = 3;
        n = 0;
        do begin
            @(negedge clk); #2;
            n++;
        end while (!(bus.imem_req && !bus.imem_ack) && n < 20);
        chk("find_wait_cycle", {31'h0, bus.imem_ack}, 32'd0);
        do_redirect(32'h0000_0300);
        @(negedge clk);
        redirect_in = 1'b0;
        #2 chk("pre_rst_state", {30'h0, state_dbg}, {30'h0, ST_DROP});
        #1 reset = 1'b0;
        #1;
        chk("arst_req", {31'h0, bus.imem_req}, 32'd0);
        chk("arst_valid", {31'h0, valid_out}, 32'd0);
        chk("arst_instr", instruction_out, 32'h0);
        chk("arst_pc4", pc_plus4_out, 32'h0);
        chk("arst_addr", bus.imem_addr, 32'h0);
        chk("arst_state", {30'h0, state_dbg}, {30'h0, ST_REQ});
        min_wait = 0;
        max_wait = 0;
        @(negedge clk);
        reset = 1'b1;
        sb_restart(32'h0);
        n = 0;
        do begin
            @(negedge clk); #2;
            n++;
        end while (!valid_out && n < 20);
        chk("restart_pc4", pc_plus4_out, 32'd4);
        chk("restart_instr", instruction_out, mem_word(32'h0));

        // Randomized traffic: wait states, stalls and redirects
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i % 500 == 0) max_wait = $urandom_range(3, 0);
            stall_in = ($urandom_range(99, 0) < 30);
            if ($urandom_range(99, 0) < 4) do_redirect($urandom);
            else redirect_in = 1'b0;
        end
        @(negedge clk);
        redirect_in = 1'b0;
        stall_in    = 1'b0;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
